// File: rtl/hud_pkg.sv
// Shared types and constants for the HUD timer overlay: colours, glyph geometry,
// region codes and the stage-1 pixel payload.
package hud_pkg;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned RGB_W   = 16;
    localparam int unsigned COORD_W = 10;

    typedef logic [RGB_W-1:0] rgb565_t;
    typedef logic [3:0]       bcd_digit_t;

    localparam rgb565_t BORDER_COLOUR_DEF = 16'h5746;
    localparam rgb565_t FG_COLOUR_DEF     = 16'hFFFF;
    localparam rgb565_t BG_COLOUR_DEF     = 16'h0000;

    typedef enum logic [1:0] {
        REG_OUTSIDE,
        REG_TIMER,
        REG_BORDER,
        REG_GAME
    } region_e;

    typedef struct packed {
        region_e          region;
        logic [COL_W-1:0] col;
        rgb565_t          game;
    } stage1_t;

endpackage

// File: rtl/digit_font_rom.sv
// 160x8 digit glyph ROM, address {digit, row}, registered read.
// Row 0 is the top of the glyph; bit 7 is the leftmost column.
module digit_font_rom
    import hud_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         addr_i,
    output logic [GLYPH_W-1:0] data_o
);

    logic [GLYPH_W*GLYPH_H-1:0] glyph_c;
    logic [GLYPH_W-1:0]         data_d;
    logic [GLYPH_W-1:0]         data_q;

    // Whole 16-row glyph per code; codes 10..15 are blank.
    always_comb begin
        glyph_c = '0;
        case (addr_i[7:4])
            4'd0:    glyph_c = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            4'd1:    glyph_c = 128'h00001838781818181818187E00000000;
            4'd2:    glyph_c = 128'h00007CC6060C183060C0C6FE00000000;
            4'd3:    glyph_c = 128'h00007CC606063C060606C67C00000000;
            4'd4:    glyph_c = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            4'd5:    glyph_c = 128'h0000FEC0C0C0FC060606C67C00000000;
            4'd6:    glyph_c = 128'h00003860C0C0FCC6C6C6C67C00000000;
            4'd7:    glyph_c = 128'h0000FEC606060C183030303000000000;
            4'd8:    glyph_c = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            4'd9:    glyph_c = 128'h00007CC6C6C67E0606060C7800000000;
            default: glyph_c = '0;
        endcase
    end

    assign data_d = GLYPH_W'(glyph_c >> {~addr_i[3:0], 3'b000});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/hud_timer_overlay.sv
// Per-pixel compositor: border, BCD elapsed-time readout and game passthrough,
// two-cycle pixel latency, plus the frame-driven seconds counter with blink-on-limit.
module hud_timer_overlay
    import hud_pkg::*;
#(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned BORDER_W       = 8,
    parameter int unsigned DIGITS         = 3,
    parameter int unsigned DIGIT_W        = GLYPH_W,
    parameter int unsigned DIGIT_H        = GLYPH_H,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter rgb565_t     BORDER_COLOUR  = BORDER_COLOUR_DEF,
    parameter rgb565_t     FG_COLOUR      = FG_COLOUR_DEF,
    parameter rgb565_t     BG_COLOUR      = BG_COLOUR_DEF
) (
    input  logic                  vga_clk,
    input  logic                  sys_rst,
    input  logic [COORD_W-1:0]    pix_x,
    input  logic [COORD_W-1:0]    pix_y,
    input  logic [RGB_W-1:0]      game_rgb,
    input  logic                  frame_start,
    input  logic                  run,
    input  logic                  clear,
    output logic [RGB_W-1:0]      pix_data,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic                  time_max
);

    localparam int unsigned TIME_W    = 4 * DIGITS;
    localparam int unsigned FC_W      = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int unsigned DIG_IDX_W = 3;
    localparam int unsigned TIME_X0   = H_ACTIVE / 2 - (DIGITS * DIGIT_W) / 2;
    localparam int unsigned TIME_X1   = TIME_X0 + DIGITS * DIGIT_W;
    localparam int unsigned TIME_Y0   = V_ACTIVE - DIGIT_H;
    localparam logic [TIME_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [FC_W-1:0]      fc_q, fc_d;
    logic [TIME_W-1:0]    time_q, time_d;
    logic                 max_q, max_d;
    logic                 blink_q, blink_d;
    logic                 tick_c;

    stage1_t              s1_q, s1_d;
    rgb565_t              pix_q, pix_d;
    logic [GLYPH_W-1:0]   rom_data;

    logic                 in_active_c, in_box_c, in_border_c, glyph_on_c;
    region_e              region_c;
    logic [COL_W-1:0]     col_c;
    logic [ROW_W-1:0]     row_c;
    logic [DIG_IDX_W-1:0] digit_idx_c;
    bcd_digit_t           nibble_c;

    function automatic logic [TIME_W-1:0] bcd_inc(input logic [TIME_W-1:0] v);
        logic [TIME_W-1:0] r;
        logic              carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Stage 0: classify the incoming pixel and address the glyph ROM.
    assign in_active_c = (pix_x < COORD_W'(H_ACTIVE)) && (pix_y < COORD_W'(V_ACTIVE));
    assign in_box_c    = (pix_x >= COORD_W'(TIME_X0)) && (pix_x < COORD_W'(TIME_X1))
                      && (pix_y >= COORD_W'(TIME_Y0));
    assign in_border_c = (pix_x < COORD_W'(BORDER_W)) || (pix_x >= COORD_W'(H_ACTIVE - BORDER_W))
                      || (pix_y < COORD_W'(BORDER_W)) || (pix_y >= COORD_W'(V_ACTIVE - BORDER_W));
    assign col_c       = COL_W'(pix_x - COORD_W'(TIME_X0));
    assign row_c       = ROW_W'(pix_y - COORD_W'(TIME_Y0));
    assign digit_idx_c = DIG_IDX_W'((pix_x - COORD_W'(TIME_X0)) >> COL_W);

    always_comb begin
        region_c = REG_GAME;
        if (!in_active_c) begin
            region_c = REG_OUTSIDE;
        end else if (in_box_c) begin
            region_c = REG_TIMER;
        end else if (in_border_c) begin
            region_c = REG_BORDER;
        end
    end

    // Digit 0 is leftmost and lives in the top nibble.
    always_comb begin
        nibble_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit_idx_c == DIG_IDX_W'(i)) begin
                nibble_c = time_q[4*(int'(DIGITS)-1-i) +: 4];
            end
        end
    end

    assign s1_d = '{region: region_c, col: col_c, game: game_rgb};

    digit_font_rom u_font (
        .clk_i  (vga_clk),
        .rst_i  (sys_rst),
        .addr_i ({nibble_c, row_c}),
        .data_o (rom_data)
    );

    // Stage 2: glyph bit select with blink blanking, then colour mux.
    always_comb begin
        glyph_on_c = rom_data[~s1_q.col] & ~blink_q;
        pix_d      = '0;
        case (s1_q.region)
            REG_TIMER:  pix_d = glyph_on_c ? FG_COLOUR : BG_COLOUR;
            REG_BORDER: pix_d = BORDER_COLOUR;
            REG_GAME:   pix_d = s1_q.game;
            default:    pix_d = '0;
        endcase
    end

    // Once saturated the frame counter free-runs to pace the blink, regardless of run.
    always_comb begin
        fc_d    = fc_q;
        time_d  = time_q;
        max_d   = max_q;
        blink_d = blink_q;
        tick_c  = 1'b0;
        if (clear) begin
            fc_d    = '0;
            time_d  = '0;
            max_d   = 1'b0;
            blink_d = 1'b0;
        end else if (frame_start && (run || max_q)) begin
            if (fc_q == FC_W'(FRAMES_PER_SEC - 1)) begin
                fc_d   = '0;
                tick_c = run;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
            if (tick_c && !max_q) begin
                time_d = bcd_inc(time_q);
                max_d  = (time_d == ALL_NINES);
            end
            if (max_d && ((fc_d == '0) || (fc_d == FC_W'(FRAMES_PER_SEC / 2)))) begin
                blink_d = ~blink_q;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_q    <= '0;
            pix_q   <= '0;
            fc_q    <= '0;
            time_q  <= '0;
            max_q   <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            pix_q   <= pix_d;
            fc_q    <= fc_d;
            time_q  <= time_d;
            max_q   <= max_d;
            blink_q <= blink_d;
        end
    end

    assign pix_data = pix_q;
    assign time_bcd = time_q;
    assign time_max = max_q;

endmodule

// File: tb/tb_hud_timer_overlay.sv
// Directed bench for hud_timer_overlay with a pixel scoreboard queue.
module tb_hud_timer_overlay;

    logic        vga_clk = 1'b0;
    logic        sys_rst;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] game_rgb;
    logic        frame_start;
    logic        run;
    logic        clear;
    logic [15:0] pix_data;
    logic [11:0] time_bcd;
    logic        time_max;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        chk;
        logic [15:0] exp;
        string       tag;
    } sb_entry_t;

    sb_entry_t sb[$];

    hud_timer_overlay dut (
        .vga_clk     (vga_clk),
        .sys_rst     (sys_rst),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .game_rgb    (game_rgb),
        .frame_start (frame_start),
        .run         (run),
        .clear       (clear),
        .pix_data    (pix_data),
        .time_bcd    (time_bcd),
        .time_max    (time_max)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [7:0] font_row(input int v, input int r);
        logic [127:0] g;
        case (v)
            0: g = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            1: g = 128'h00001838781818181818187E00000000;
            2: g = 128'h00007CC6060C183060C0C6FE00000000;
            3: g = 128'h00007CC606063C060606C67C00000000;
            4: g = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            5: g = 128'h0000FEC0C0C0FC060606C67C00000000;
            6: g = 128'h00003860C0C0FCC6C6C6C67C00000000;
            7: g = 128'h0000FEC606060C183030303000000000;
            8: g = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            9: g = 128'h00007CC6C6C67E0606060C7800000000;
            default: g = '0;
        endcase
        return g[8*(15-r) +: 8];
    endfunction

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, queue its expectation, retire the entry whose output is now due.
    task automatic pix(input int x, input int y, input logic [15:0] rgb,
                       input logic chk, input logic [15:0] exp, input string tag);
        sb_entry_t e;
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        game_rgb = rgb;
        e.chk = chk;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
        @(posedge vga_clk);
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            if (e.chk) check16(e.tag, pix_data, e.exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            @(posedge vga_clk);
            #1;
        end
        frame_start = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge vga_clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int          rx[6];
        int          ry[6];
        logic [15:0] rexp[6];
        logic [7:0]  row;
        logic [15:0] exp_on;

        sys_rst = 1'b1;
        pix_x = '0; pix_y = '0; game_rgb = '0;
        frame_start = 1'b0; run = 1'b0; clear = 1'b0;
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        check16("init_pix", pix_data, 16'h0000);
        check16("init_bcd", 16'(time_bcd), 16'h0000);
        check16("init_max", 16'(time_max), 16'h0000);
        sys_rst = 1'b0;

        // Regions
        rx = '{0, 8, 639, 307, 700, 100};
        ry = '{100, 100, 479, 470, 100, 500};
        rexp = '{16'h5746, 16'h1234, 16'h5746, 16'h1234, 16'h0000, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            pix(rx[i], ry[i], 16'h1234, 1'b1, rexp[i], $sformatf("region_%0d_%0d", rx[i], ry[i]));
        end
        pix(0, 0, 16'h0000, 1'b0, 16'h0000, "flush");

        // Counting
        run = 1'b1;
        frames(60);
        check16("cnt_60", 16'(time_bcd), 16'h0001);
        frames(540);
        check16("cnt_600", 16'(time_bcd), 16'h0010);
        run = 1'b0;
        frames(120);
        check16("cnt_hold", 16'(time_bcd), 16'h0010);
        check16("cnt_hold_max", 16'(time_max), 16'h0000);

        // Asynchronous reset mid-frame
        run = 1'b1;
        pix(100, 100, 16'h1234, 1'b1, 16'h1234, "pre_rst_a");
        pix(100, 100, 16'h1234, 1'b1, 16'h1234, "pre_rst_b");
        check16("pre_rst_pix", pix_data, 16'h1234);
        #2;
        sys_rst = 1'b1;
        #1;
        check16("rst_pix", pix_data, 16'h0000);
        check16("rst_bcd", 16'(time_bcd), 16'h0000);
        check16("rst_max", 16'(time_max), 16'h0000);
        @(posedge vga_clk);
        #1;
        sys_rst = 1'b0;
        sb.delete();
        pix(8, 100, 16'h1234, 1'b1, 16'h1234, "resume_game");
        check16("resume_lat1", pix_data, 16'h0000);
        pix(0, 100, 16'h1234, 1'b1, 16'h5746, "resume_border");
        pix(0, 0, 16'h0000, 1'b0, 16'h0000, "flush");

        // Glyph rendering of 1-2-3
        run = 1'b1;
        frames(7380);
        check16("cnt_123", 16'(time_bcd), 16'h0123);
        for (int y = 464; y < 480; y++) begin
            for (int x = 308; x < 332; x++) begin
                row = font_row((x - 308) / 8 + 1, y - 464);
                pix(x, y, 16'h1234, 1'b1, row[7 - ((x - 308) % 8)] ? 16'hFFFF : 16'h0000,
                    $sformatf("glyph_%0d_%0d", x, y));
            end
        end
        pix(0, 0, 16'h0000, 1'b0, 16'h0000, "flush");

        // Saturation and blink
        clear_pulse();
        frames(59939);
        check16("sat_998", 16'(time_bcd), 16'h0998);
        check16("sat_998_max", 16'(time_max), 16'h0000);
        frames(1);
        check16("sat_999", 16'(time_bcd), 16'h0999);
        check16("sat_999_max", 16'(time_max), 16'h0001);
        for (int k = 0; k < 90; k++) begin
            if (k == 45) run = 1'b0;
            exp_on = (((k / 30) % 2) == 0) ? 16'h0000 : 16'hFFFF;
            pix(309, 466, 16'h1234, 1'b1, exp_on, $sformatf("blink_on_%0d", k));
            pix(308, 466, 16'h1234, 1'b1, 16'h0000, $sformatf("blink_off_%0d", k));
            pix(0, 0, 16'h0000, 1'b0, 16'h0000, "flush");
            frames(1);
        end
        check16("sat_hold", 16'(time_bcd), 16'h0999);
        check16("sat_hold_max", 16'(time_max), 16'h0001);

        // Clear priority over a coincident tick
        clear_pulse();
        check16("clr_bcd", 16'(time_bcd), 16'h0000);
        check16("clr_max", 16'(time_max), 16'h0000);
        pix(309, 466, 16'h1234, 1'b1, 16'hFFFF, "clr_glyph_visible");
        pix(0, 0, 16'h0000, 1'b0, 16'h0000, "flush");
        run = 1'b1;
        frames(59);
        frame_start = 1'b1;
        clear = 1'b1;
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
        clear = 1'b0;
        check16("clr_prio", 16'(time_bcd), 16'h0000);
        frames(59);
        check16("clr_59", 16'(time_bcd), 16'h0000);
        frames(1);
        check16("clr_60", 16'(time_bcd), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
